regfile_scheduler: RTL and testbench
====================================

REGFILE_SCHEDULER -- requirements
Module: regfile_scheduler

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on posedge clk.
REQ-002 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports issue_valid in 1, issue_op in 2, issue_we in 1: instruction offered, opcode (2'b11 = long op), writes destination.
REQ-004 SHALL have ports issue_rn, issue_rm, issue_ra, issue_rd  in  4 each: first, second and fourth source registers, and the destination register.
REQ-005 SHALL have port stall  out  1  issue refused this cycle (combinational).
REQ-006 SHALL have ports alu_wb_valid in 1, alu_wb_rd in 4, alu_wb_data in 32: single-cycle ALU result, never back-pressured.
REQ-007 SHALL have ports long_wb_valid in 1, long_wb_rd in 4, long_wb_data in 32, long_wb_ready out 1: long-op result with valid/ready handshake.
REQ-008 SHALL have ports WE out 1, destination_register out 4, WD out 32: registered drive of the register-file write port.
REQ-009 SHALL have ports busy_mask out 15, long_pend out 1, wb_err out 1, stall_cnt out 16.

Function
REQ-010 SHALL keep one scoreboard bit per R0..R14 (busy_mask[i] = write to Ri outstanding); R15 is never busy.
REQ-011 SHALL assert stall when issue_valid and any of: busy[rn]; busy[rm]; busy[rd] (WAW); op==2'b11 and busy[ra]; op==2'b11 and long_pend.
REQ-012 SHALL treat register index 15 in any source/destination field as never busy.
REQ-013 SHALL accept an issue when issue_valid && !stall; on acceptance with issue_we=1 and rd!=15 SHALL set busy[rd] next edge.
REQ-014 SHALL run a two-state FSM IDLE/LONG_PEND: IDLE->LONG_PEND on accepted op 2'b11; LONG_PEND->IDLE on accepted long writeback; long_pend=1 in LONG_PEND.
REQ-015 SHALL give the ALU fixed priority: long_wb_ready = !alu_wb_valid; a long writeback is accepted when long_wb_valid && long_wb_ready.
REQ-016 SHALL, on an accepted writeback with rd!=15, drive WE=1, destination_register=rd, WD=data on the next edge (latency 1), and WE=0 otherwise.
REQ-017 SHALL clear busy[rd] at the same edge that WE is asserted for that rd.
REQ-018 SHALL, on simultaneous set and clear of the same bit, give set priority.
REQ-019 SHALL not assert WE for a writeback with rd=15; it SHALL set wb_err instead (FSM still leaves LONG_PEND if it was a long writeback).
REQ-020 SHALL still perform a writeback to a non-busy register, and SHALL set wb_err.
REQ-021 SHALL hold wb_err sticky until reset.
REQ-022 SHALL increment stall_cnt on every cycle with issue_valid && stall, saturating at 16'hFFFF.
REQ-023 SHALL hold a long_wb_valid producer's data unchanged while long_wb_ready=0 (producer obligation; the scheduler does not buffer).

Reset
REQ-024 SHALL, on rst=1 at posedge clk, set busy_mask=0, FSM=IDLE, WE=0, destination_register=0, WD=0, wb_err=0, stall_cnt=0.
REQ-025 SHALL ignore all issue and writeback inputs in a reset cycle; a long op in flight at reset is abandoned.

Configuration
REQ-026 SHALL support macro RF_SCHED_BYPASS_EN: when defined, busy bits cleared by a writeback accepted in the current cycle SHALL NOT cause stall that cycle.
REQ-027 SHALL, without RF_SCHED_BYPASS_EN, compute stall from the registered busy_mask only (no same-cycle release).

Verification
REQ-028 SHALL cover: issue rd=3 we=1 op=00 -> busy_mask[3]=1; alu_wb rd=3 data=32'hA5 -> next cycle WE=1, destination_register=3, WD=32'hA5, busy_mask[3]=0.
REQ-029 SHALL cover: busy[5]=1, issue rn=5 -> stall=1, stall_cnt +1 per cycle; same cycle as alu_wb rd=5: stall=0 only with RF_SCHED_BYPASS_EN.
REQ-030 SHALL cover: issue op=11 rd=7 -> long_pend=1; second op=11 -> stall; alu_wb_valid and long_wb_valid in the same cycle -> ALU written first, long_wb_ready=0, long written next cycle, long_pend=0.
REQ-031 SHALL cover: alu_wb rd=15 -> WE stays 0, wb_err=1; alu_wb to non-busy R2 -> WE=1, wb_err=1.
REQ-032 SHALL cover: rst mid LONG_PEND with busy_mask=15'h00F0 -> next cycle busy_mask=0, long_pend=0, WE=0, stall_cnt=0.

Source files
------------

// File: rtl/regfile_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scheduler
// Description : Register-file scoreboard and write-port scheduler.
//               Tracks outstanding writes to R0..R14, refuses issue on
//               RAW/WAW hazards or a second long op, and arbitrates the
//               single-cycle ALU and the long-op result onto one registered
//               register-file write port (ALU has fixed priority).
// Ports       : clk, rst (synchronous, active-high)
//               issue_valid/op/we/rn/rm/ra/rd -> stall (combinational)
//               alu_wb_valid/rd/data           (never back-pressured)
//               long_wb_valid/rd/data -> long_wb_ready
//               WE, destination_register, WD   (registered write port)
//               busy_mask, long_pend, wb_err, stall_cnt (status)
// Options     : RF_SCHED_BYPASS_EN - when defined, a busy bit released by a
//               writeback accepted this cycle does not cause stall this cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [1:0]  issue_op,
    input  logic        issue_we,
    input  logic [3:0]  issue_rn,
    input  logic [3:0]  issue_rm,
    input  logic [3:0]  issue_ra,
    input  logic [3:0]  issue_rd,
    output logic        stall,
    input  logic        alu_wb_valid,
    input  logic [3:0]  alu_wb_rd,
    input  logic [31:0] alu_wb_data,
    input  logic        long_wb_valid,
    input  logic [3:0]  long_wb_rd,
    input  logic [31:0] long_wb_data,
    output logic        long_wb_ready,
    output logic        WE,
    output logic [3:0]  destination_register,
    output logic [31:0] WD,
    output logic [14:0] busy_mask,
    output logic        long_pend,
    output logic        wb_err,
    output logic [15:0] stall_cnt
);

    localparam logic [1:0]  c_OP_LONG  = 2'b11;
    localparam logic [3:0]  c_R15      = 4'd15;
    localparam logic [15:0] c_CNT_MAX  = 16'hFFFF;

    typedef enum logic [0:0] {
        S_IDLE      = 1'b0,
        S_LONG_PEND = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [14:0] r_busy;
    logic        r_we;
    logic [3:0]  r_dest;
    logic [31:0] r_wd;
    logic        r_wb_err;
    logic [15:0] r_stall_cnt;

    logic        w_long_acc;
    logic        w_wb_acc;
    logic [3:0]  w_wb_rd;
    logic [31:0] w_wb_data;
    logic        w_wb_write;
    logic        w_wb_err_evt;
    logic        w_accept;
    logic        w_is_long;
    logic [14:0] w_set_mask;
    logic [14:0] w_clr_mask;
    logic [14:0] w_hazard_busy;
    logic [14:0] w_busy_nxt;
    logic        w_stall;

    // Index 15 reads as never busy: the mask is widened with a constant 0.
    function automatic logic f_busy(input logic [14:0] mask, input logic [3:0] idx);
        logic [15:0] m;
        m = {1'b0, mask};
        return m[idx];
    endfunction

    // ------------------------------------------------------------------
    // Writeback arbitration: at most one result is taken per cycle and
    // the ALU always wins, so the long producer must hold its data.
    // ------------------------------------------------------------------
    always_comb begin
        w_long_acc   = long_wb_valid && !alu_wb_valid;
        w_wb_acc     = alu_wb_valid || w_long_acc;
        w_wb_rd      = alu_wb_valid ? alu_wb_rd   : long_wb_rd;
        w_wb_data    = alu_wb_valid ? alu_wb_data : long_wb_data;
        w_wb_write   = w_wb_acc && (w_wb_rd != c_R15);
        // R15 or a register with no outstanding write both flag an error.
        w_wb_err_evt = w_wb_acc && !f_busy(r_busy, w_wb_rd);
        w_clr_mask   = '0;
        for (int i = 0; i < 15; i++) begin
            w_clr_mask[i] = w_wb_write && (w_wb_rd == 4'(i));
        end
    end

`ifdef RF_SCHED_BYPASS_EN
    // Same-cycle release: a bit being cleared now no longer blocks issue.
    assign w_hazard_busy = r_busy & ~w_clr_mask;
`else
    assign w_hazard_busy = r_busy;
`endif

    // ------------------------------------------------------------------
    // Hazard detection and issue acceptance
    // ------------------------------------------------------------------
    always_comb begin
        w_is_long = (issue_op == c_OP_LONG);
        w_stall   = issue_valid && (f_busy(w_hazard_busy, issue_rn) ||
                                    f_busy(w_hazard_busy, issue_rm) ||
                                    f_busy(w_hazard_busy, issue_rd) ||
                                    (w_is_long && f_busy(w_hazard_busy, issue_ra)) ||
                                    (w_is_long && (r_state == S_LONG_PEND)));
        w_accept  = issue_valid && !w_stall;
        w_set_mask = '0;
        for (int i = 0; i < 15; i++) begin
            w_set_mask[i] = w_accept && issue_we && (issue_rd == 4'(i));
        end
        // Set wins over clear when an issue and a writeback hit the same bit.
        w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;
    end

    // ------------------------------------------------------------------
    // Long-op FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_long) begin
                    w_state_nxt = S_LONG_PEND;
                end
            end
            S_LONG_PEND: begin
                if (w_long_acc) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard, write port and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= '0;
            r_we        <= 1'b0;
            r_dest      <= '0;
            r_wd        <= '0;
            r_wb_err    <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_we   <= w_wb_write;
            if (w_wb_write) begin
                r_dest <= w_wb_rd;
                r_wd   <= w_wb_data;
            end
            if (w_wb_err_evt) begin
                r_wb_err <= 1'b1;
            end
            if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign stall                = w_stall;
    assign long_wb_ready        = !alu_wb_valid;
    assign WE                   = r_we;
    assign destination_register = r_dest;
    assign WD                   = r_wd;
    assign busy_mask            = r_busy;
    assign long_pend            = (r_state == S_LONG_PEND);
    assign wb_err               = r_wb_err;
    assign stall_cnt            = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_scheduler
// Description : Directed self-checking bench for regfile_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scheduler;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [1:0]  issue_op;
    logic        issue_we;
    logic [3:0]  issue_rn;
    logic [3:0]  issue_rm;
    logic [3:0]  issue_ra;
    logic [3:0]  issue_rd;
    logic        stall;
    logic        alu_wb_valid;
    logic [3:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;
    logic        long_wb_valid;
    logic [3:0]  long_wb_rd;
    logic [31:0] long_wb_data;
    logic        long_wb_ready;
    logic        WE;
    logic [3:0]  destination_register;
    logic [31:0] WD;
    logic [14:0] busy_mask;
    logic        long_pend;
    logic        wb_err;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_scheduler u_dut (
        .clk                  (clk),
        .rst                  (rst),
        .issue_valid          (issue_valid),
        .issue_op             (issue_op),
        .issue_we             (issue_we),
        .issue_rn             (issue_rn),
        .issue_rm             (issue_rm),
        .issue_ra             (issue_ra),
        .issue_rd             (issue_rd),
        .stall                (stall),
        .alu_wb_valid         (alu_wb_valid),
        .alu_wb_rd            (alu_wb_rd),
        .alu_wb_data          (alu_wb_data),
        .long_wb_valid        (long_wb_valid),
        .long_wb_rd           (long_wb_rd),
        .long_wb_data         (long_wb_data),
        .long_wb_ready        (long_wb_ready),
        .WE                   (WE),
        .destination_register (destination_register),
        .WD                   (WD),
        .busy_mask            (busy_mask),
        .long_pend            (long_pend),
        .wb_err               (wb_err),
        .stall_cnt            (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; registered outputs are stable here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs follow freshly driven inputs.
    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid   = 1'b0;
        issue_op      = 2'b00;
        issue_we      = 1'b0;
        issue_rn      = 4'd0;
        issue_rm      = 4'd0;
        issue_ra      = 4'd0;
        issue_rd      = 4'd0;
        alu_wb_valid  = 1'b0;
        alu_wb_rd     = 4'd0;
        alu_wb_data   = 32'h0;
        long_wb_valid = 1'b0;
        long_wb_rd    = 4'd0;
        long_wb_data  = 32'h0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] rn, input logic [3:0] rm,
                         input logic [3:0] ra, input logic [3:0] rd);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_we    = 1'b1;
        issue_rn    = rn;
        issue_rm    = rm;
        issue_ra    = ra;
        issue_rd    = rd;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_busy",  32'(busy_mask), 32'h0);
        check("rst_lpend", 32'(long_pend), 32'h0);
        check("rst_we",    32'(WE), 32'h0);
        check("rst_dest",  32'(destination_register), 32'h0);
        check("rst_wd",    WD, 32'h0);
        check("rst_err",   32'(wb_err), 32'h0);
        check("rst_cnt",   32'(stall_cnt), 32'h0);

        // Issue to R3, then ALU writeback of R3
        issue(2'b00, 4'd0, 4'd0, 4'd0, 4'd3);
        settle();
        check("t1_stall0", 32'(stall), 32'h0);
        tick();
        idle_inputs();
        check("t1_busy3", 32'(busy_mask), 32'h0008);
        // Fourth source only matters for a long op
        issue(2'b11, 4'd0, 4'd0, 4'd3, 4'd9);
        settle();
        check("t1_ra_long", 32'(stall), 32'h1);
        issue(2'b00, 4'd0, 4'd0, 4'd3, 4'd9);
        settle();
        check("t1_ra_short", 32'(stall), 32'h0);
        idle_inputs();
        alu_wb_valid = 1'b1;
        alu_wb_rd    = 4'd3;
        alu_wb_data  = 32'hA5;
        tick();
        idle_inputs();
        check("t1_we",   32'(WE), 32'h1);
        check("t1_dest", 32'(destination_register), 32'h3);
        check("t1_wd",   WD, 32'hA5);
        check("t1_busy", 32'(busy_mask), 32'h0);
        check("t1_err",  32'(wb_err), 32'h0);
        tick();
        check("t1_we_off", 32'(WE), 32'h0);

        // RAW stall on R5, stall counting, release by ALU writeback
        issue(2'b00, 4'd0, 4'd0, 4'd0, 4'd5);
        tick();
        issue(2'b00, 4'd5, 4'd0, 4'd0, 4'd6);
        settle();
        check("t2_stall", 32'(stall), 32'h1);
        tick();
        tick();
        check("t2_cnt2",  32'(stall_cnt), 32'h2);
        check("t2_busy",  32'(busy_mask), 32'h0020);
        alu_wb_valid = 1'b1;
        alu_wb_rd    = 4'd5;
        alu_wb_data  = 32'h55;
        settle();
`ifdef RF_SCHED_BYPASS_EN
        check("t2_bypass_stall", 32'(stall), 32'h0);
`else
        check("t2_bypass_stall", 32'(stall), 32'h1);
`endif
        tick();
        idle_inputs();
        check("t2_we",   32'(WE), 32'h1);
        check("t2_dest", 32'(destination_register), 32'h5);
`ifdef RF_SCHED_BYPASS_EN
        check("t2_cnt_after",  32'(stall_cnt), 32'h2);
        check("t2_busy_after", 32'(busy_mask), 32'h0040);
`else
        check("t2_cnt_after",  32'(stall_cnt), 32'h3);
        check("t2_busy_after", 32'(busy_mask), 32'h0);
`endif
        do_reset();

        // Long op, second long refused, ALU priority over long writeback
        issue(2'b11, 4'd0, 4'd0, 4'd0, 4'd7);
        tick();
        check("t3_lpend", 32'(long_pend), 32'h1);
        check("t3_busy7", 32'(busy_mask), 32'h0080);
        issue(2'b11, 4'd0, 4'd0, 4'd0, 4'd8);
        settle();
        check("t3_long2_stall", 32'(stall), 32'h1);
        issue(2'b00, 4'd0, 4'd0, 4'd7, 4'd4);
        settle();
        check("t3_short_ok", 32'(stall), 32'h0);
        tick();
        idle_inputs();
        check("t3_busy47", 32'(busy_mask), 32'h0090);
        alu_wb_valid  = 1'b1;
        alu_wb_rd     = 4'd4;
        alu_wb_data   = 32'h44;
        long_wb_valid = 1'b1;
        long_wb_rd    = 4'd7;
        long_wb_data  = 32'h77;
        settle();
        check("t3_ready0", 32'(long_wb_ready), 32'h0);
        tick();
        alu_wb_valid = 1'b0;
        check("t3_alu_dest", 32'(destination_register), 32'h4);
        check("t3_alu_wd",   WD, 32'h44);
        check("t3_lpend_hold", 32'(long_pend), 32'h1);
        check("t3_busy_7only", 32'(busy_mask), 32'h0080);
        settle();
        check("t3_ready1", 32'(long_wb_ready), 32'h1);
        tick();
        idle_inputs();
        check("t3_long_we",   32'(WE), 32'h1);
        check("t3_long_dest", 32'(destination_register), 32'h7);
        check("t3_long_wd",   WD, 32'h77);
        check("t3_lpend0",    32'(long_pend), 32'h0);
        check("t3_busy0",     32'(busy_mask), 32'h0);
        check("t3_err0",      32'(wb_err), 32'h0);
        check("t3_cnt0",      32'(stall_cnt), 32'h0);

        // R15 never becomes busy and never blocks
        issue(2'b00, 4'd15, 4'd15, 4'd15, 4'd15);
        settle();
        check("t4_r15_stall", 32'(stall), 32'h0);
        tick();
        idle_inputs();
        check("t4_r15_busy", 32'(busy_mask), 32'h0);

        // Writeback to R15: no write, error flagged
        alu_wb_valid = 1'b1;
        alu_wb_rd    = 4'd15;
        alu_wb_data  = 32'hDEAD;
        tick();
        idle_inputs();
        check("t4_r15_we",  32'(WE), 32'h0);
        check("t4_r15_err", 32'(wb_err), 32'h1);
        tick();
        check("t4_err_sticky", 32'(wb_err), 32'h1);
        do_reset();
        check("t4_err_rst", 32'(wb_err), 32'h0);

        // Writeback to non-busy R2: still written, error flagged
        alu_wb_valid = 1'b1;
        alu_wb_rd    = 4'd2;
        alu_wb_data  = 32'h22;
        tick();
        idle_inputs();
        check("t4_r2_we",   32'(WE), 32'h1);
        check("t4_r2_dest", 32'(destination_register), 32'h2);
        check("t4_r2_wd",   WD, 32'h22);
        check("t4_r2_err",  32'(wb_err), 32'h1);
        do_reset();

        // Reset in the middle of a long op
        issue(2'b11, 4'd0, 4'd0, 4'd0, 4'd4);
        tick();
        issue(2'b00, 4'd0, 4'd0, 4'd0, 4'd5);
        tick();
        issue(2'b00, 4'd0, 4'd0, 4'd0, 4'd6);
        tick();
        issue(2'b00, 4'd0, 4'd0, 4'd0, 4'd7);
        tick();
        issue(2'b00, 4'd0, 4'd0, 4'd0, 4'd5);
        settle();
        check("t5_waw", 32'(stall), 32'h1);
        issue(2'b00, 4'd0, 4'd6, 4'd0, 4'd9);
        settle();
        check("t5_rm", 32'(stall), 32'h1);
        tick();
        tick();
        idle_inputs();
        check("t5_busy",  32'(busy_mask), 32'h00F0);
        check("t5_lpend", 32'(long_pend), 32'h1);
        check("t5_cnt",   32'(stall_cnt), 32'h2);
        rst          = 1'b1;
        alu_wb_valid = 1'b1;
        alu_wb_rd    = 4'd4;
        alu_wb_data  = 32'h99;
        issue(2'b00, 4'd0, 4'd0, 4'd0, 4'd9);
        tick();
        rst = 1'b0;
        idle_inputs();
        check("t5_rst_busy",  32'(busy_mask), 32'h0);
        check("t5_rst_lpend", 32'(long_pend), 32'h0);
        check("t5_rst_we",    32'(WE), 32'h0);
        check("t5_rst_cnt",   32'(stall_cnt), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
